// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - pipelined group multiplier: activation FIFO, double-buffered weight, stallable product pipe
module mul_pipe #(
    parameter int GROUP_SIZE             = 8,
    parameter int DATA_WIDTH             = 8,
    parameter int WEIGHT_WIDTH           = 8,
    parameter int PIPE_STAGES            = 2,
    parameter int FIFO_DEPTH             = 4,
    parameter int LOG_FIFO_DEPTH         = 2,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         configure,
    input  logic [LOG_MAX_ITERS-1:0]                     num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]            num_reads_per_iter,
    input  logic                                         signed_mode,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]             act_data_in,
    input  logic                                         act_valid_in,
    output logic                                         act_avail_out,
    input  logic [WEIGHT_WIDTH-1:0]                      weight_data_in,
    input  logic                                         weight_valid_in,
    output logic                                         weight_avail_out,
    output logic [GROUP_SIZE*(DATA_WIDTH+WEIGHT_WIDTH)-1:0] data_out,
    output logic                                         valid_out,
    input  logic                                         avail_in,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow_err
);

    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int GW = GROUP_SIZE * DATA_WIDTH;
    localparam int OW = GROUP_SIZE * PW;
    localparam int CW = LOG_FIFO_DEPTH + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AVAIL_MAX = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state, state_nx;
    logic   done_nx;

    // activation fifo
    logic [GW-1:0]             fifo_mem [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]             fifo_cnt;
    logic                      fifo_full, fifo_empty, act_wr;
    logic [GW-1:0]             fifo_head;

    // weight buffer
    logic [WEIGHT_WIDTH-1:0]   cur_w, next_w;
    logic                      next_valid, w_load, w_wr;

    // run control
    logic [LOG_MAX_ITERS-1:0]          iters_left;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_left, reads_cfg;
    logic                              sgn;
    logic                              cfg_zero;

    // product pipeline
    logic [PIPE_STAGES-1:0]         stage_valid;
    logic [PIPE_STAGES-1:0][OW-1:0] stage_data;
    logic                           pipe_adv, fire;
    logic [PW-1:0]                  w_ext;
    logic [PW-1:0]                  act_ext [GROUP_SIZE];
    logic [OW-1:0]                  prod;

    assign fifo_full     = (fifo_cnt == FULL_CNT);
    assign fifo_empty    = (fifo_cnt == '0);
    assign act_wr        = act_valid_in & ~fifo_full;
    assign act_avail_out = (fifo_cnt <= AVAIL_MAX);
    assign fifo_head     = fifo_mem[rd_ptr];

    assign pipe_adv = ~stage_valid[PIPE_STAGES-1] | avail_in;
    assign fire     = (state == S_RUN) & ~fifo_empty & pipe_adv;

    // A write landing in the same cycle the next slot is consumed refills it.
    assign w_load           = (state == S_LOAD_W) & next_valid;
    assign w_wr             = weight_valid_in & (~next_valid | w_load);
    assign weight_avail_out = ~next_valid;

    assign cfg_zero = (num_iters == '0) | (num_reads_per_iter == '0);

    always_ff @(posedge clk) begin
        if (act_wr) begin
            fifo_mem[wr_ptr] <= act_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (act_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({act_wr, fire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_w        <= '0;
            next_w       <= '0;
            next_valid   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (w_load) begin
                cur_w <= next_w;
            end
            if (w_wr) begin
                next_w     <= weight_data_in;
                next_valid <= 1'b1;
            end else if (w_load) begin
                next_valid <= 1'b0;
            end
            if ((act_valid_in & fifo_full) | (weight_valid_in & next_valid & ~w_load)) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (configure) begin
                    if (cfg_zero) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (next_valid) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (fire && reads_left == LOG_MAX_READS_PER_ITER'(1)) begin
                    state_nx = (iters_left == LOG_MAX_ITERS'(1)) ? S_DRAIN : S_LOAD_W;
                end
            end
            S_DRAIN: begin
                if (stage_valid == '0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            iters_left <= '0;
            reads_left <= '0;
            reads_cfg  <= '0;
            sgn        <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            case (state)
                S_IDLE: begin
                    if (configure && !cfg_zero) begin
                        iters_left <= num_iters;
                        reads_cfg  <= num_reads_per_iter;
                        sgn        <= signed_mode;
                    end
                end
                S_LOAD_W: begin
                    if (next_valid) begin
                        reads_left <= reads_cfg;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (reads_left == LOG_MAX_READS_PER_ITER'(1)) begin
                            if (iters_left != LOG_MAX_ITERS'(1)) begin
                                iters_left <= iters_left - 1'b1;
                            end
                        end else begin
                            reads_left <= reads_left - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands widened to PW bits; the low PW bits of the product are exact in both modes.
    always_comb begin
        w_ext = sgn ? {{DATA_WIDTH{cur_w[WEIGHT_WIDTH-1]}}, cur_w}
                    : {{DATA_WIDTH{1'b0}}, cur_w};
        prod  = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            act_ext[i] = sgn ? {{WEIGHT_WIDTH{fifo_head[i*DATA_WIDTH+DATA_WIDTH-1]}}, fifo_head[i*DATA_WIDTH +: DATA_WIDTH]}
                             : {{WEIGHT_WIDTH{1'b0}}, fifo_head[i*DATA_WIDTH +: DATA_WIDTH]};
            prod[i*PW +: PW] = act_ext[i] * w_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= '0;
            stage_data  <= '0;
        end else if (pipe_adv) begin
            stage_valid[0] <= fire;
            if (fire) begin
                stage_data[0] <= prod;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    assign valid_out = stage_valid[PIPE_STAGES-1];
    assign data_out  = stage_data[PIPE_STAGES-1];
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - directed/randomized bench for mul_pipe with reference product model
module tb_mul_pipe;

    localparam int GS = 8;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int PW = DW + WW;
    localparam int GW = GS * DW;
    localparam int BW = GS * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          configure;
    logic [15:0]   num_iters;
    logic [15:0]   num_reads_per_iter;
    logic          signed_mode;
    logic [GW-1:0] act_data_in;
    logic          act_valid_in;
    logic          act_avail_out;
    logic [WW-1:0] weight_data_in;
    logic          weight_valid_in;
    logic          weight_avail_out;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          avail_in;
    logic          busy;
    logic          done;
    logic          overflow_err;

    mul_pipe dut (
        .clk                (clk),
        .rst                (rst),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .signed_mode        (signed_mode),
        .act_data_in        (act_data_in),
        .act_valid_in       (act_valid_in),
        .act_avail_out      (act_avail_out),
        .weight_data_in     (weight_data_in),
        .weight_valid_in    (weight_valid_in),
        .weight_avail_out   (weight_avail_out),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .avail_in           (avail_in),
        .busy               (busy),
        .done               (done),
        .overflow_err       (overflow_err)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            beats = 0;
    int            done_cnt = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] last_beat = '0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Each item taken as an integer (two's complement when signed), multiplied, kept modulo 2^PW.
    function automatic logic [BW-1:0] model(input logic [GW-1:0] acts, input logic [WW-1:0] w, input bit sg);
        logic [BW-1:0] r;
        longint a, b, p;
        r = '0;
        b = longint'(w);
        if (sg && b >= (64'sd1 << (WW-1))) b = b - (64'sd1 << WW);
        for (int i = 0; i < GS; i++) begin
            a = longint'(acts[i*DW +: DW]);
            if (sg && a >= (64'sd1 << (DW-1))) a = a - (64'sd1 << DW);
            p = a * b;
            r[i*PW +: PW] = p[PW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", BW'(valid_out), BW'(1));
                chk("hold_data", data_out, prev_data);
            end
            if (valid_out && avail_in) begin
                chk("beat_expected", BW'(exp_q.size() > 0), BW'(1));
                if (exp_q.size() > 0) chk("beat_data", data_out, exp_q.pop_front());
                last_beat = data_out;
                beats++;
            end
            prev_stall = valid_out && !avail_in;
            prev_data  = data_out;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_act(input logic [GW-1:0] a);
        int n = 0;
        while (!act_avail_out && n < 300) begin
            tick();
            n++;
        end
        chk("act_avail_wait", BW'(act_avail_out), BW'(1));
        act_data_in  = a;
        act_valid_in = 1'b1;
        tick();
        act_valid_in = 1'b0;
    endtask

    task automatic push_w(input logic [WW-1:0] w);
        int n = 0;
        while (!weight_avail_out && n < 300) begin
            tick();
            n++;
        end
        chk("weight_avail_wait", BW'(weight_avail_out), BW'(1));
        weight_data_in  = w;
        weight_valid_in = 1'b1;
        tick();
        weight_valid_in = 1'b0;
    endtask

    task automatic start(input int it, input int rd, input bit sg);
        num_iters          = 16'(it);
        num_reads_per_iter = 16'(rd);
        signed_mode        = sg;
        configure          = 1'b1;
        tick();
        configure = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", BW'(done), BW'(1));
        tick();
        chk("done_one_cycle", BW'(done), BW'(0));
        chk("queue_drained", BW'(exp_q.size()), BW'(0));
        chk("busy_after_done", BW'(busy), BW'(0));
    endtask

    function automatic logic [GW-1:0] rnd_group();
        logic [GW-1:0] g;
        for (int i = 0; i < GS; i++) g[i*DW +: DW] = DW'($urandom);
        return g;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GW-1:0] g;
        logic [WW-1:0] w;
        logic [BW-1:0] exp1;
        int b0, d0, n;

        rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
        signed_mode = 1'b0; act_data_in = '0; act_valid_in = 1'b0;
        weight_data_in = '0; weight_valid_in = 1'b0; avail_in = 1'b1;
        tick();
        chk("rst_valid_out", BW'(valid_out), BW'(0));
        chk("rst_data_out", data_out, '0);
        chk("rst_done", BW'(done), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_overflow", BW'(overflow_err), BW'(0));
        chk("rst_act_avail", BW'(act_avail_out), BW'(1));
        chk("rst_weight_avail", BW'(weight_avail_out), BW'(1));
        tick();
        rst = 1'b1;
        tick();

        // zero-length configurations complete immediately
        start(0, 5, 0);
        chk("zero_iters_done", BW'(done), BW'(1));
        chk("zero_iters_busy", BW'(busy), BW'(0));
        tick();
        start(3, 0, 0);
        chk("zero_reads_done", BW'(done), BW'(1));
        tick();
        chk("zero_reads_pulse", BW'(done), BW'(0));

        // 1: single beat, unsigned, latency check
        push_w(8'd3);
        for (int i = 0; i < GS; i++) g[i*DW +: DW] = DW'(i + 1);
        exp_q.push_back(model(g, 8'd3, 0));
        push_act(g);
        start(1, 1, 0);
        chk("t1_busy", BW'(busy), BW'(1));
        tick(); tick();
        chk("t1_not_yet_valid", BW'(valid_out), BW'(0));
        tick();
        chk("t1_valid", BW'(valid_out), BW'(1));
        for (int i = 0; i < GS; i++) exp1[i*PW +: PW] = PW'(3 * (i + 1));
        chk("t1_data", data_out, exp1);
        wait_done(40);

        // 2: signed corner values
        g = rnd_group();
        g[7:0] = 8'h7F;
        g[15:8] = 8'h80;
        push_w(8'hFE);
        exp_q.push_back(model(g, 8'hFE, 1));
        push_act(g);
        start(1, 1, 1);
        wait_done(40);
        chk("t2_pos_item", BW'(last_beat[15:0]), BW'(16'hFF02));
        chk("t2_neg_item", BW'(last_beat[31:16]), BW'(16'h0100));

        // 3: three iterations of four reads, weights 1,2,3
        b0 = beats; d0 = done_cnt;
        push_w(8'd1);
        start(3, 4, 0);
        push_w(8'd2);
        for (int k = 0; k < 12; k++) begin
            if (k == 4) push_w(8'd3);
            g = rnd_group();
            exp_q.push_back(model(g, WW'(k / 4 + 1), 0));
            push_act(g);
        end
        wait_done(100);
        chk("t3_beats", BW'(beats - b0), BW'(12));
        chk("t3_one_done", BW'(done_cnt - d0), BW'(1));

        // 4: downstream stall, fifo fill and overflow
        avail_in = 1'b0;
        w = WW'($urandom);
        push_w(w);
        start(1, 6, 0);
        for (int k = 0; k < 5; k++) begin
            g = rnd_group();
            exp_q.push_back(model(g, w, 0));
            push_act(g);
        end
        chk("t4_act_avail_low", BW'(act_avail_out), BW'(0));
        g = rnd_group();
        exp_q.push_back(model(g, w, 0));
        act_data_in = g; act_valid_in = 1'b1;
        tick();
        chk("t4_margin_write_ok", BW'(overflow_err), BW'(0));
        act_data_in = rnd_group();
        tick();
        act_valid_in = 1'b0;
        chk("t4_overflow", BW'(overflow_err), BW'(1));
        for (int k = 0; k < 3; k++) tick();
        chk("t4_stall_valid", BW'(valid_out), BW'(1));
        chk("t4_stall_data", data_out, exp_q[0]);
        avail_in = 1'b1;
        wait_done(60);
        chk("t4_overflow_sticky", BW'(overflow_err), BW'(1));

        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t4_overflow_cleared", BW'(overflow_err), BW'(0));

        // 5: second weight withheld
        b0 = beats;
        w = WW'($urandom);
        push_w(w);
        start(2, 2, 1);
        for (int k = 0; k < 2; k++) begin
            g = rnd_group();
            exp_q.push_back(model(g, w, 1));
            push_act(g);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_iter1_drained", BW'(exp_q.size()), BW'(0));
        w = WW'($urandom);
        for (int k = 0; k < 2; k++) begin
            g = rnd_group();
            exp_q.push_back(model(g, w, 1));
            push_act(g);
        end
        for (int k = 0; k < 8; k++) tick();
        chk("t5_waiting_busy", BW'(busy), BW'(1));
        chk("t5_no_fire", BW'(valid_out), BW'(0));
        chk("t5_beats_held", BW'(beats - b0), BW'(2));
        push_w(w);
        wait_done(60);
        chk("t5_beats", BW'(beats - b0), BW'(4));

        // 6: reset mid-run
        d0 = done_cnt;
        push_w(WW'($urandom));
        start(1, 4, 0);
        push_act(rnd_group());
        push_act(rnd_group());
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid_out", BW'(valid_out), BW'(0));
        chk("t6_data_out", data_out, '0);
        chk("t6_busy", BW'(busy), BW'(0));
        chk("t6_done", BW'(done), BW'(0));
        chk("t6_act_avail", BW'(act_avail_out), BW'(1));
        chk("t6_weight_avail", BW'(weight_avail_out), BW'(1));
        chk("t6_overflow", BW'(overflow_err), BW'(0));
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_no_done_on_abort", BW'(done_cnt - d0), BW'(0));
        b0 = beats;
        w = WW'($urandom);
        push_w(w);
        start(1, 2, 1);
        for (int k = 0; k < 2; k++) begin
            g = rnd_group();
            exp_q.push_back(model(g, w, 1));
            push_act(g);
        end
        wait_done(60);
        chk("t6_fresh_beats", BW'(beats - b0), BW'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
